// File: rtl/block_window_loader_if.sv
// block_window_loader_if
//   Request, BRAM-read and row-buffer signals of one search-window loader.
//   master : the loader (drives ready/read strobe/address/buffers/valid)
//   slave  : the requester / frame memory / SSD consumer side
//   Ports (names as seen by the loader):
//     start_in, word_col_in, row_in  - load request
//     ready_out                      - loader idle
//     rd_en_out, rd_addr_out         - BRAM read strobe and word address
//     rd_data_in                     - BRAM word, RD_LAT cycles after rd_en_out
//     back_buffer_out, front_buffer_out - 6 x 48-bit row words (col, col+1)
//     block_idx_out, block_y_out     - pixel x of back word, top row
//     valid_out                      - one-cycle "buffers complete" pulse
interface block_window_loader_if #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 320
);
  localparam int WPR    = IMG_WIDTH / 6;
  localparam int COL_W  = $clog2(WPR) + 1;
  localparam int ROW_W  = $clog2(IMG_HEIGHT) + 1;
  localparam int ADDR_W = $clog2(WPR * IMG_HEIGHT);
  localparam int IDX_W  = $clog2(240) + 1;
  localparam int BY_W   = $clog2(320) + 1;

  logic                   start_in;
  logic [COL_W-1:0]       word_col_in;
  logic [ROW_W-1:0]       row_in;
  logic                   ready_out;
  logic                   rd_en_out;
  logic [ADDR_W-1:0]      rd_addr_out;
  logic [47:0]            rd_data_in;
  logic [5:0][47:0]       back_buffer_out;
  logic [5:0][47:0]       front_buffer_out;
  logic [IDX_W-1:0]       block_idx_out;
  logic [BY_W-1:0]        block_y_out;
  logic                   valid_out;

  modport master (
    input  start_in, word_col_in, row_in, rd_data_in,
    output ready_out, rd_en_out, rd_addr_out, back_buffer_out,
           front_buffer_out, block_idx_out, block_y_out, valid_out
  );

  modport slave (
    output start_in, word_col_in, row_in, rd_data_in,
    input  ready_out, rd_en_out, rd_addr_out, back_buffer_out,
           front_buffer_out, block_idx_out, block_y_out, valid_out
  );
endinterface

// File: rtl/block_window_loader.sv
// block_window_loader
//   Fetches a 6-row x 2-word (12-pixel) window from frame BRAM and packs it
//   into back (column word_col) and front (column word_col+1) row buffers.
//   Fixed latency: start sampled in cycle 0, reads in cycles 1..12,
//   valid_out in cycle 13+RD_LAT, ready again in cycle 14+RD_LAT.
//   Ports:
//     clk_in   - clock
//     rst_n_in - asynchronous active-low reset
//     bus      - block_window_loader_if.master (request, BRAM read, buffers)
//   Build option: define LOADER_ZERO_PAD_EN to load out-of-image words as
//   zero (no read issued); otherwise coordinates clamp to the image edge.
module block_window_loader #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 320,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  block_window_loader_if.master         bus
);
  localparam int WPR    = IMG_WIDTH / 6;
  localparam int COL_W  = $clog2(WPR) + 1;
  localparam int ROW_W  = $clog2(IMG_HEIGHT) + 1;
  localparam int ADDR_W = $clog2(WPR * IMG_HEIGHT);
  localparam int IDX_W  = $clog2(240) + 1;
  localparam int BY_W   = $clog2(320) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  // Travels alongside the BRAM read so the returning word knows its slot.
  typedef struct packed {
    logic [2:0] r;
    logic       front;
    logic       zero;
  } tag_t;

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BY_W-1:0]   by_q, by_d;
  logic [5:0][47:0]  back_q, front_q;

  logic [RD_LAT:1]   vld_pipe_q;
  tag_t              tag_pipe_q [RD_LAT:1];

  logic              issue;
  tag_t              slot_tag;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              ready, valid;

  // Slot geometry: k>>1 is the row offset, k[0] picks the front word.
  logic [31:0]       tgt_row, tgt_col, eff_row, eff_col;
  logic              slot_oob;

  always_comb begin
    tgt_row  = 32'(row_q) + 32'(k_q[3:1]);
    tgt_col  = 32'(col_q) + 32'(k_q[0]);
    slot_oob = (tgt_row >= 32'(IMG_HEIGHT)) || (tgt_col >= 32'(WPR));
    // Clamped coordinates replicate the edge; in range they are identity.
    eff_row  = (tgt_row >= 32'(IMG_HEIGHT)) ? 32'(IMG_HEIGHT - 1) : tgt_row;
    eff_col  = (tgt_col >= 32'(WPR))        ? 32'(WPR - 1)        : tgt_col;
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    col_d          = col_q;
    row_d          = row_q;
    idx_d          = idx_q;
    by_d           = by_q;
    issue          = 1'b0;
    rd_en          = 1'b0;
    rd_addr        = '0;
    ready          = 1'b0;
    valid          = 1'b0;
    slot_tag.r     = k_q[3:1];
    slot_tag.front = k_q[0];
`ifdef LOADER_ZERO_PAD_EN
    slot_tag.zero  = slot_oob;
`else
    slot_tag.zero  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.start_in) begin
          col_d   = bus.word_col_in;
          row_d   = bus.row_in;
          idx_d   = IDX_W'(32'(bus.word_col_in) * 32'd6);
          by_d    = BY_W'(bus.row_in);
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
`ifdef LOADER_ZERO_PAD_EN
        rd_en   = ~slot_oob;
`else
        rd_en   = 1'b1;
`endif
        rd_addr = ADDR_W'(eff_row * 32'(WPR) + eff_col);
        if (k_q == 4'd11) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      // k is reused to count the RD_LAT cycles the last tag needs to land.
      DRAIN: begin
        if (k_q == 4'(RD_LAT - 1)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      k_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      by_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      by_q    <= by_d;
    end
  end

  // Tag pipeline: stage RD_LAT lines up with rd_data_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe_q <= '0;
      for (int i = 1; i <= RD_LAT; i++) tag_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[1] <= issue;
      tag_pipe_q[1] <= slot_tag;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  // Buffers only change on capture, so they hold from valid_out until the
  // next load's first returning word.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      back_q  <= '0;
      front_q <= '0;
    end else if (vld_pipe_q[RD_LAT]) begin
      if (tag_pipe_q[RD_LAT].front)
        front_q[tag_pipe_q[RD_LAT].r] <= tag_pipe_q[RD_LAT].zero ? 48'h0 : bus.rd_data_in;
      else
        back_q[tag_pipe_q[RD_LAT].r]  <= tag_pipe_q[RD_LAT].zero ? 48'h0 : bus.rd_data_in;
    end
  end

  assign bus.ready_out        = ready;
  assign bus.rd_en_out        = rd_en;
  assign bus.rd_addr_out      = rd_addr;
  assign bus.valid_out        = valid;
  assign bus.back_buffer_out  = back_q;
  assign bus.front_buffer_out = front_q;
  assign bus.block_idx_out    = idx_q;
  assign bus.block_y_out      = by_q;
endmodule
